// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: selects the write-back value,
// commits it, and serves two write-first bypassed read ports plus a raw debug port.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] MemData,
    input  logic [DATA_W-1:0] ALUData,
    input  logic [ADDR_W-1:0] Rw,
    input  logic              MemtoReg,
    input  logic              RegWr,
    input  logic              Overflow,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic [DATA_W-1:0] WbData,
    output logic              WbEn,
    input  logic              ovf_clr,
    output logic              ovf_flag,
    output logic [31:0]       wb_count,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              ovf_q;
    logic [31:0]       cnt_q;

    assign WbData   = MemtoReg ? MemData : ALUData;
    assign WbEn     = RegWr & ~Overflow & (Rw != '0);
    assign ovf_flag = ovf_q;
    assign wb_count = cnt_q;

    // Write-first bypass so ID sees the value being committed this cycle.
    always_comb begin
        busA = '0;
        if (Ra != '0) begin
            if (WbEn && (Ra == Rw)) busA = WbData;
            else                    busA = regs[Ra];
        end
    end

    always_comb begin
        busB = '0;
        if (Rb != '0) begin
            if (WbEn && (Rb == Rw)) busB = WbData;
            else                    busB = regs[Rb];
        end
    end

    always_comb begin
        dbg_data = '0;
        if (dbg_addr != '0) dbg_data = regs[dbg_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (WbEn) begin
            regs[Rw] <= WbData;
        end
    end

    // Set has priority over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (RegWr && Overflow) ovf_q <= 1'b1;
            else if (ovf_clr)      ovf_q <= 1'b0;
            if (WbEn) cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: behavioural register-file model, per-cycle
// compare process, directed cases and randomized traffic.
`timescale 1ns/1ps
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] MemData = '0, ALUData = '0;
    logic [4:0]  Rw = '0, Ra = '0, Rb = '0, dbg_addr = '0;
    logic        MemtoReg = 1'b0, RegWr = 1'b0, Overflow = 1'b0, ovf_clr = 1'b0;
    logic [31:0] busA, busB, WbData, dbg_data, wb_count;
    logic        WbEn, ovf_flag;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n), .MemData(MemData), .ALUData(ALUData), .Rw(Rw),
        .MemtoReg(MemtoReg), .RegWr(RegWr), .Overflow(Overflow), .Ra(Ra), .Rb(Rb),
        .busA(busA), .busB(busB), .WbData(WbData), .WbEn(WbEn), .ovf_clr(ovf_clr),
        .ovf_flag(ovf_flag), .wb_count(wb_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_wb();
        return MemtoReg ? MemData : ALUData;
    endfunction

    function automatic logic m_wen();
        return RegWr && !Overflow && (Rw != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit bypass);
        if (a == 0) return 32'h0;
        if (bypass && m_wen() && a == Rw) return m_wb();
        return m_regs[a];
    endfunction

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_cnt = '0;
        m_ovf = 1'b0;
    end

    // Reference model: state advances on the clock, clears immediately on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_cnt = '0;
            m_ovf = 1'b0;
        end else begin
            if (m_wen()) begin
                m_regs[Rw] = m_wb();
                m_cnt = m_cnt + 1;
            end
            if (RegWr && Overflow) m_ovf = 1'b1;
            else if (ovf_clr)      m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cyc_WbData", WbData, m_wb());
            chk("cyc_WbEn", {31'b0, WbEn}, {31'b0, m_wen()});
            chk("cyc_busA", busA, m_read(Ra, 1'b1));
            chk("cyc_busB", busB, m_read(Rb, 1'b1));
            chk("cyc_dbg", dbg_data, m_read(dbg_addr, 1'b0));
            chk("cyc_ovf", {31'b0, ovf_flag}, {31'b0, m_ovf});
            chk("cyc_count", wb_count, m_cnt);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWr = 0; Overflow = 0; ovf_clr = 0; MemtoReg = 0;
    endtask

    initial begin
        repeat (2) cycle();
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_count", wb_count, 32'h0);
        chk("rst_ovf", {31'b0, ovf_flag}, 32'h0);

        // Mux and commit
        RegWr = 1; MemtoReg = 0; ALUData = 32'h1234; MemData = 32'h9999; Rw = 5; dbg_addr = 5;
        cycle();
        idle();
        #1;
        chk("commit_alu", dbg_data, 32'h1234);
        chk("commit_count", wb_count, 32'h1);
        RegWr = 1; MemtoReg = 1; MemData = 32'hCAFE; ALUData = 32'h1111; Rw = 6; dbg_addr = 6;
        cycle();
        idle();
        #1;
        chk("commit_mem", dbg_data, 32'hCAFE);

        // Bypass
        RegWr = 1; ALUData = 32'hA5A5; Rw = 7; Ra = 7; Rb = 7; dbg_addr = 7;
        #1;
        chk("byp_busA", busA, 32'hA5A5);
        chk("byp_busB", busB, 32'hA5A5);
        chk("byp_dbg_old", dbg_data, 32'h0);
        cycle();
        idle();

        // Writes to $0
        RegWr = 1; Rw = 0; ALUData = 32'hFFFF; Ra = 0;
        #1;
        chk("r0_wben", {31'b0, WbEn}, 32'h0);
        chk("r0_busA", busA, 32'h0);
        cycle();
        idle();
        #1;
        chk("r0_count", wb_count, 32'h3);

        // Overflow
        RegWr = 1; Overflow = 1; Rw = 3; ALUData = 32'hDEAD; dbg_addr = 3;
        cycle();
        idle();
        #1;
        chk("ovf_set", {31'b0, ovf_flag}, 32'h1);
        chk("ovf_noreg", dbg_data, 32'h0);
        RegWr = 1; Overflow = 1; ovf_clr = 1; Rw = 3;
        cycle();
        idle();
        #1;
        chk("ovf_setwins", {31'b0, ovf_flag}, 32'h1);
        ovf_clr = 1;
        cycle();
        idle();
        #1;
        chk("ovf_clr", {31'b0, ovf_flag}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            RegWr    = ($urandom_range(0, 3) != 0);
            Overflow = ($urandom_range(0, 7) == 0);
            ovf_clr  = ($urandom_range(0, 7) == 0);
            MemtoReg = $urandom_range(0, 1);
            MemData  = $urandom;
            ALUData  = $urandom;
            Rw       = $urandom_range(0, 31);
            Ra       = ($urandom_range(0, 3) == 0) ? Rw : 5'($urandom_range(0, 31));
            Rb       = ($urandom_range(0, 3) == 0) ? Rw : 5'($urandom_range(0, 31));
            dbg_addr = $urandom_range(0, 31);
            cycle();
        end
        idle();

        // Counter wrap
        force dut.cnt_q = 32'hFFFFFFFE;
        #0.1;
        release dut.cnt_q;
        m_cnt = 32'hFFFFFFFE;
        RegWr = 1; Rw = 9; ALUData = 32'h55;
        cycle();
        chk("wrap_max", wb_count, 32'hFFFFFFFF);
        cycle();
        idle();
        #1;
        chk("wrap_zero", wb_count, 32'h0);

        // Mid-run async reset with a flagged overflow
        RegWr = 1; Overflow = 1; Rw = 2;
        cycle();
        idle();
        Ra = 5; Rb = 6;
        rst_n = 1'b0;
        #0.1;
        chk("arst_count", wb_count, 32'h0);
        chk("arst_ovf", {31'b0, ovf_flag}, 32'h0);
        chk("arst_busA", busA, 32'h0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #0.05;
            chk("arst_dbg", dbg_data, 32'h0);
        end
        RegWr = 1; Rw = 4; ALUData = 32'h77;
        cycle();
        rst_n = 1'b1;
        idle();
        dbg_addr = 4;
        #1;
        chk("arst_discard", dbg_data, 32'h0);
        RegWr = 1; Rw = 4; ALUData = 32'h88;
        cycle();
        idle();
        #1;
        chk("post_rst_commit", dbg_data, 32'h88);
        chk("post_rst_count", wb_count, 32'h1);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
